fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage plus the F/D pipeline register of the five-stage MIPS pipeline. It holds the PC, drives the instruction-memory address, and latches the fetched word into D. Each cycle it picks the next PC from the branch/jump decision resolved in D by the branch comparator. Under configuration, it nullifies the delay slot of a not-taken branch-likely instruction.

## Interface
- `PC_RESET`, default `32'h0000_3000`: PC value loaded on reset.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `f_instr` input 32: instruction-memory read data for `f_pc`; combinational, same cycle.
- `stall` input 1: hazard-unit stall; freezes the PC and the F/D register.
- `npc_op` input 2: D-stage next-PC select, `NPC_PC4` / `NPC_BR` / `NPC_J` / `NPC_JR`.
- `br_taken` input 1: D-stage comparator result for a conditional branch.
- `null_signal` input 1: D-stage branch-likely not-taken; discard the delay slot.
- `d_rs` input 32: forwarded rs value in D, used as the JR target.
- `f_pc` output 32: fetch address to instruction memory.
- `d_instr` output 32: instruction held in D.
- `d_pc` output 32: PC of `d_instr`.
- `d_pc8` output 32: `d_pc + 8`, the link value.
- `d_valid` output 1: 0 when D holds a bubble or a nullified slot.

## Operation
- The D-stage immediate and index come from the block's own `d_instr`: imm16 = `[15:0]`, index26 = `[25:0]`.
- Next-PC calculation, all arithmetic modulo 2^32:
  - `NPC_PC4`: `f_pc + 4`.
  - `NPC_BR`: if `br_taken`, `d_pc + 4 + (sext(imm16) << 2)`; otherwise `f_pc + 4`.
  - `NPC_J`: `{d_pc_plus4[31:28], index26, 2'b00}`.
  - `NPC_JR`: `d_rs`; the low two bits are passed unchanged.
- Delay slot: a redirect does not flush F. The instruction in F enters D normally.
- Nullify (only with the configuration macro defined): when `null_signal` = 1 and `stall` = 0:
  - D loads `32'h0000_0000` with `d_valid` = 0.
  - `d_pc` loads the discarded slot's PC.
  - The PC advances to `f_pc + 4`.
- Update priority on each edge: `reset` > `stall` > (nullify and/or redirect) > sequential.
  - With `stall` = 1, the PC, `d_instr`, `d_pc` and `d_valid` all hold.
  - `npc_op`, `br_taken` and `null_signal` are ignored while stalled. They are re-evaluated when the stall drops, because D still holds the branch.
- Nullify and redirect are independent. `null_signal` with `npc_op` = `NPC_BR` and `br_taken` = 0 takes the sequential path plus the flush.
- Reset values:
  - `f_pc` = `PC_RESET`.
  - `d_instr` = 0.
  - `d_pc` = `PC_RESET - 4`.
  - `d_valid` = 0.
  - `d_pc8` = `PC_RESET + 4`.
- Reset asserted mid-branch discards any pending redirect.

## Timing
- One register stage from F to D: `f_instr` sampled at edge N appears on `d_instr` after edge N.
- Redirect latency is one cycle. A branch in D at cycle N sets `f_pc` = target after the edge closing cycle N. The slot fetched in cycle N reaches D in cycle N+1.
- `f_pc` is a register output with no combinational path from the inputs.
- `d_pc8` is combinational from `d_pc`.
- The next-PC mux is combinational from `npc_op`, `br_taken`, `d_rs` and `d_instr` into the PC register's D input.

## Configuration
- `BRANCH_LIKELY_EN` defined: nullify behaves as described under Operation.
- `BRANCH_LIKELY_EN` undefined:
  - `null_signal` is ignored and no flush logic is synthesized.
  - `d_valid` is 1 after the first post-reset edge, except across a stall.

## Structure
- The `NPC_*` 2-bit encodings and `NOP` (`32'h0`) go in the shared constants header, alongside the instruction-type codes.
- One sub-module, `npc_calc`: purely combinational, computes the next PC from `npc_op`, `br_taken`, `f_pc`, `d_pc`, `d_instr` and `d_rs`.
- `fetch_stage` holds the PC register, the F/D register and the nullify/stall control.

## Test plan
- Reset, then 3 cycles of `NPC_PC4`, no stall → `f_pc` goes `3000`, `3004`, `3008`, `300C`; `d_pc` lags `f_pc` by one cycle; `d_valid` = 1 from the second cycle.
- `d_pc` = `3010`, imm16 = `FFFE`, `NPC_BR`, `br_taken` = 1 → next `f_pc` = `300C`; the slot at `3014` enters D with `d_valid` = 1.
- `NPC_J` with index26 = `0000C10` at `d_pc` = `3020` → `f_pc` = `00003040`; `NPC_JR` with `d_rs` = `00003100` → `f_pc` = `00003100`.
- `stall` = 1 for 2 cycles while `NPC_BR` and `br_taken` = 1 → PC and D hold both cycles; the redirect occurs on the first unstalled edge.
- Macro defined: `null_signal` = 1 at `d_pc` = `3030` → D = `00000000`, `d_valid` = 0, `d_pc` = `3034`, `f_pc` = `3038`. Macro undefined: the same stimulus gives `d_instr` = `f_instr` and `d_valid` = 1.
- `reset` asserted in the same cycle as a taken branch → `f_pc` = `3000`, `d_valid` = 0; the target is not fetched.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared constants for the fetch stage of the five-stage MIPS pipeline:
//   - npc_op_e : 2-bit next-PC select codes driven by the D-stage control
//   - NOP      : all-zero instruction word used for bubbles and flushed slots
//   - opcode_e : primary opcode field codes for the instruction types that
//                influence control flow
//   - branch_offset() : sign-extended, word-scaled branch displacement
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      NPC_PC4 = 2'b00,
      NPC_BR  = 2'b01,
      NPC_J   = 2'b10,
      NPC_JR  = 2'b11
   } npc_op_e;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef enum logic [5:0] {
      OP_SPECIAL = 6'h00,
      OP_REGIMM  = 6'h01,
      OP_J       = 6'h02,
      OP_JAL     = 6'h03,
      OP_BEQ     = 6'h04,
      OP_BNE     = 6'h05,
      OP_BEQL    = 6'h14,
      OP_BNEL    = 6'h15
   } opcode_e;

   // The 16-bit branch immediate counts words, so it is sign-extended and
   // shifted left by two to form a byte displacement.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
      return {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// ---------------------------------------------------------------------------
// npc_calc
// Purely combinational next-PC selection for the fetch stage.
// Ports:
//   npc_op   in  [1:0]  next-PC select (npc_op_e encoding)
//   br_taken in         conditional branch resolved taken in D
//   f_pc     in  [31:0] current fetch address
//   d_pc     in  [31:0] PC of the instruction held in D
//   d_instr  in  [31:0] instruction held in D (supplies imm16 / index26)
//   d_rs     in  [31:0] forwarded rs value, JR target
//   npc      out [31:0] next fetch address
// ---------------------------------------------------------------------------
module npc_calc
   import fetch_stage_pkg::*;
(
   input  logic [1:0]  npc_op,
   input  logic        br_taken,
   input  logic [31:0] f_pc,
   input  logic [31:0] d_pc,
   input  logic [31:0] d_instr,
   input  logic [31:0] d_rs,
   output logic [31:0] npc
);

   logic [31:0] d_pc_plus4;
   logic [31:0] seq_target;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [5:0]  unused_opcode;

   // The opcode field is decoded elsewhere; only imm16 and index26 matter here.
   assign unused_opcode = d_instr[31:26];

   assign d_pc_plus4 = d_pc + 32'd4;
   assign seq_target = f_pc + 32'd4;
   assign br_target  = d_pc_plus4 + branch_offset(d_instr[15:0]);
   // Jumps stay inside the 256 MB region of the delay slot, hence d_pc + 4.
   assign j_target   = {d_pc_plus4[31:28], d_instr[25:0], 2'b00};

   always_comb begin
      npc = seq_target;
      case (npc_op_e'(npc_op))
         NPC_PC4: npc = seq_target;
         NPC_BR:  npc = br_taken ? br_target : seq_target;
         NPC_J:   npc = j_target;
         NPC_JR:  npc = d_rs;
         default: npc = seq_target;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage plus the F/D pipeline register. Holds the PC,
// drives the instruction-memory address and latches the fetched word into D.
// Redirects do not flush F: the instruction fetched alongside a branch in D
// (the delay slot) always enters D.
//
// Configuration macro: BRANCH_LIKELY_EN
//   defined   : null_signal nullifies the delay slot of a not-taken
//               branch-likely (D loads NOP with d_valid = 0)
//   undefined : null_signal is ignored, no flush logic exists
//
// Ports:
//   clk         in         rising-edge clock
//   reset       in         synchronous, active-high
//   f_instr     in  [31:0] instruction-memory read data for f_pc
//   stall       in         freeze PC and F/D register
//   npc_op      in  [1:0]  D-stage next-PC select
//   br_taken    in         D-stage branch comparator result
//   null_signal in         D-stage branch-likely not taken
//   d_rs        in  [31:0] forwarded rs value (JR target)
//   f_pc        out [31:0] fetch address
//   d_instr     out [31:0] instruction held in D
//   d_pc        out [31:0] PC of d_instr
//   d_pc8       out [31:0] d_pc + 8 (link value)
//   d_valid     out        0 when D holds a bubble or nullified slot
// ---------------------------------------------------------------------------
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] f_instr,
   input  logic        stall,
   input  logic [1:0]  npc_op,
   input  logic        br_taken,
   input  logic        null_signal,
   input  logic [31:0] d_rs,
   output logic [31:0] f_pc,
   output logic [31:0] d_instr,
   output logic [31:0] d_pc,
   output logic [31:0] d_pc8,
   output logic        d_valid
);

   logic [31:0] f_pc_q, f_pc_d;
   logic [31:0] d_instr_q, d_instr_d;
   logic [31:0] d_pc_q, d_pc_d;
   logic        d_valid_q, d_valid_d;
   logic [31:0] npc;

   npc_calc u_npc_calc (
      .npc_op   (npc_op),
      .br_taken (br_taken),
      .f_pc     (f_pc_q),
      .d_pc     (d_pc_q),
      .d_instr  (d_instr_q),
      .d_rs     (d_rs),
      .npc      (npc)
   );

`ifndef BRANCH_LIKELY_EN
   logic unused_null_signal;
   assign unused_null_signal = null_signal;
`endif

   // Stall holds everything; otherwise the PC follows the next-PC mux and the
   // fetched word moves into D. A nullify only replaces what D captures, so
   // it composes freely with whatever the next-PC mux selected.
   always_comb begin
      f_pc_d    = f_pc_q;
      d_instr_d = d_instr_q;
      d_pc_d    = d_pc_q;
      d_valid_d = d_valid_q;
      if (!stall) begin
         f_pc_d    = npc;
         d_instr_d = f_instr;
         d_pc_d    = f_pc_q;
         d_valid_d = 1'b1;
`ifdef BRANCH_LIKELY_EN
         if (null_signal) begin
            d_instr_d = NOP;
            d_valid_d = 1'b0;
         end
`endif
      end
   end

   // d_pc resets to PC_RESET - 4 so the link value d_pc + 8 reads PC_RESET + 4.
   always_ff @(posedge clk) begin
      if (reset) begin
         f_pc_q    <= PC_RESET;
         d_instr_q <= NOP;
         d_pc_q    <= PC_RESET - 32'd4;
         d_valid_q <= 1'b0;
      end else begin
         f_pc_q    <= f_pc_d;
         d_instr_q <= d_instr_d;
         d_pc_q    <= d_pc_d;
         d_valid_q <= d_valid_d;
      end
   end

   assign f_pc    = f_pc_q;
   assign d_instr = d_instr_q;
   assign d_pc    = d_pc_q;
   assign d_pc8   = d_pc_q + 32'd8;
   assign d_valid = d_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Scoreboard bench for fetch_stage. Each stimulus cycle advances a plain
// behavioural model of the PC / D registers and queues the state expected
// after the next rising edge; an independent monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] PC_RESET = 32'h0000_3000;

   typedef struct {
      int          cycle;
      logic [31:0] f_pc;
      logic [31:0] d_instr;
      logic [31:0] d_pc;
      logic [31:0] d_pc8;
      logic        d_valid;
   } expect_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] f_instr;
   logic        stall;
   logic [1:0]  npc_op;
   logic        br_taken;
   logic        null_signal;
   logic [31:0] d_rs;
   logic [31:0] f_pc;
   logic [31:0] d_instr;
   logic [31:0] d_pc;
   logic [31:0] d_pc8;
   logic        d_valid;

   expect_t     exp_q[$];
   int          tests_run = 0;
   int          tests_failed = 0;
   int          cycle_no = 0;

   // Reference model state
   logic [31:0] m_fpc;
   logic [31:0] m_dinstr;
   logic [31:0] m_dpc;
   logic        m_dvalid;

   fetch_stage #(.PC_RESET(PC_RESET)) dut (
      .clk         (clk),
      .reset       (reset),
      .f_instr     (f_instr),
      .stall       (stall),
      .npc_op      (npc_op),
      .br_taken    (br_taken),
      .null_signal (null_signal),
      .d_rs        (d_rs),
      .f_pc        (f_pc),
      .d_instr     (d_instr),
      .d_pc        (d_pc),
      .d_pc8       (d_pc8),
      .d_valid     (d_valid)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs on the falling edge and queue the model's
   // expectation for the state after the following rising edge.
   task automatic applyStimulus(input logic rst, input logic stl, input int op,
                                input logic tkn, input logic nul,
                                input logic [31:0] rs, input logic [31:0] instr);
      logic [31:0] next_pc;
      logic signed [31:0] disp;
      expect_t e;
      @(negedge clk);
      reset = rst; stall = stl; npc_op = 2'(op); br_taken = tkn;
      null_signal = nul; d_rs = rs; f_instr = instr;
      if (rst) begin
         m_fpc = PC_RESET; m_dinstr = 32'h0; m_dpc = PC_RESET - 4; m_dvalid = 1'b0;
      end else if (!stl) begin
         disp = 32'($signed(m_dinstr[15:0]));
         case (op)
            1:       next_pc = tkn ? (m_dpc + 4 + 32'(disp * 4)) : (m_fpc + 4);
            2:       next_pc = ((m_dpc + 4) & 32'hF000_0000) | (32'(m_dinstr[25:0]) * 4);
            3:       next_pc = rs;
            default: next_pc = m_fpc + 4;
         endcase
         m_dpc = m_fpc;
`ifdef BRANCH_LIKELY_EN
         if (nul) begin
            m_dinstr = 32'h0; m_dvalid = 1'b0;
         end else begin
            m_dinstr = instr; m_dvalid = 1'b1;
         end
`else
         m_dinstr = instr; m_dvalid = 1'b1;
`endif
         m_fpc = next_pc;
      end
      cycle_no++;
      e.cycle = cycle_no; e.f_pc = m_fpc; e.d_instr = m_dinstr;
      e.d_pc = m_dpc; e.d_pc8 = m_dpc + 8; e.d_valid = m_dvalid;
      exp_q.push_back(e);
   endtask

   task automatic checkField(input string name, input int cyc,
                             input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic checkOutput(input expect_t e);
      checkField("f_pc",    e.cycle, f_pc,    e.f_pc);
      checkField("d_instr", e.cycle, d_instr, e.d_instr);
      checkField("d_pc",    e.cycle, d_pc,    e.d_pc);
      checkField("d_pc8",   e.cycle, d_pc8,   e.d_pc8);
      checkField("d_valid", e.cycle, 32'(d_valid), 32'(e.d_valid));
   endtask

   // Sequential fetch until the model PC reaches the wanted address.
   task automatic stepTo(input logic [31:0] addr);
      int n = 0;
      while (m_fpc != addr && n < 64) begin
         applyStimulus(0, 0, 0, 0, 0, 32'h0, $urandom);
         n++;
      end
      if (m_fpc != addr) begin
         tests_run++; tests_failed++;
         $display("[TB] FAIL stepTo: model pc %h, expected %h", m_fpc, addr);
      end
   endtask

   // Monitor: the stage presents new state after every rising edge.
   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      int op;
      logic tkn, nul;
      reset = 1'b1; stall = 1'b0; npc_op = 2'd0; br_taken = 1'b0;
      null_signal = 1'b0; d_rs = 32'h0; f_instr = 32'h0;
      m_fpc = PC_RESET; m_dinstr = 32'h0; m_dpc = PC_RESET - 4; m_dvalid = 1'b0;

      // Reset, then sequential fetch
      applyStimulus(1, 0, 0, 0, 0, 32'h0, $urandom);
      stepTo(32'h0000_3010);
      // Branch with imm16 = FFFE from d_pc = 3010 -> 300C
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h1000_FFFE);
      applyStimulus(0, 0, 1, 1, 0, 32'h0, $urandom);
      // Jump with index26 = 0000C10 from d_pc = 3020 -> 3040, then JR -> 3100
      stepTo(32'h0000_3020);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0800_0C10);
      applyStimulus(0, 0, 2, 0, 0, 32'h0, $urandom);
      applyStimulus(0, 0, 3, 0, 0, 32'h0000_3100, $urandom);
      // Branch held through a two-cycle stall, redirect on first free edge
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h1000_0010);
      applyStimulus(0, 1, 1, 1, 0, 32'h0, $urandom);
      applyStimulus(0, 1, 1, 1, 1, 32'h0, $urandom);
      applyStimulus(0, 0, 1, 1, 0, 32'h0, $urandom);
      // Nullify at d_pc = 3030
      applyStimulus(0, 0, 3, 0, 0, 32'h0000_3030, $urandom);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h5000_0004);
      applyStimulus(0, 0, 1, 0, 1, 32'h0, 32'hDEAD_BEEF);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, $urandom);
      // Reset coinciding with a taken branch
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h1000_0040);
      applyStimulus(1, 0, 1, 1, 0, 32'h0, $urandom);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, $urandom);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         op  = int'($urandom_range(0, 3));
         tkn = 1'($urandom);
         // branch-likely nullify only arises on a non-redirecting cycle
         nul = (($urandom_range(0, 3) == 0) && (op == 0 || (op == 1 && !tkn)));
         applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                       op, tkn, nul, $urandom, $urandom);
      end

      @(negedge clk);
      reset = 1'b0; stall = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         tests_run++; tests_failed++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
